// File: rtl/tcm_pkg.sv
// Shared types and constants for the tightly-coupled memory.
package tcm_pkg;

   // CPU port handshake states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2
   } tcm_state_e;

   // Supported read latency window; stage 1 is the RAM register, so 2 is the floor
   localparam int RD_LAT_MIN = 2;
   localparam int RD_LAT_MAX = 4;

   // Ceiling log2, used for address widths
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/tcm_ram_lane.sv
// One byte lane of the TCM: 8-bit true dual-port RAM with registered reads.
// Port A serves the configuration path, port B the CPU. Reads return the
// pre-write contents when a port reads and writes the same word.
module tcm_ram_lane
   import tcm_pkg::*;
#(
   parameter int DEPTH = 32768,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [7:0]    a_wdata,
   output logic [7:0]    a_rdata,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [7:0]    b_wdata,
   output logic [7:0]    b_rdata
);

   logic [7:0] mem [DEPTH];

   // Both ports in one process; callers guarantee the two write enables never hit the same word
   always_ff @(posedge clk) begin
      if (b_we) mem[b_addr] <= b_wdata;
      if (a_we) mem[a_addr] <= a_wdata;
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
   end

endmodule

// File: rtl/tcm_memory.sv
// Tightly-coupled instruction/data memory: CPU port with byte strobes and a
// held-request / one-cycle-ready handshake, plus a pipelined configuration
// port for host load and readback. Configuration writes win word collisions.
module tcm_memory
   import tcm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32768,
   parameter int RD_LAT = 2      // 2..4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_wren,
   input  logic              mem_rden,
   input  logic [31:0]       mem_addr,
   input  logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_err,
   input  logic              conf_sel,
   input  logic              conf_rden,
   input  logic              conf_wren,
   input  logic [31:0]       conf_addr,
   input  logic [DATA_W-1:0] conf_wdata,
   output logic [DATA_W-1:0] conf_rdata,
   output logic              conf_rvalid
);

   localparam int NL = DATA_W / 8;
   localparam int AW = clog2(DEPTH);

   tcm_state_e                state;
   logic [1:0]                cnt;
   logic                      err_q;
   logic                      cpu_acc, cpu_wr_acc, cpu_rd_acc, cpu_oor;
   logic                      conf_oor, conf_we_ok, collide;
   logic [AW-1:0]             cpu_word, conf_word;
   logic [NL-1:0]             cpu_lane_we;
   logic [NL-1:0][7:0]        cpu_q, conf_q;
   logic                      cpu_ok_q, conf_ok_q;
   logic [RD_LAT:1]           conf_vld_pipe;
   logic [RD_LAT:2][DATA_W-1:0] cpu_d_pipe, conf_d_pipe;
   logic                      unused_addr_bits;

   assign cpu_word   = mem_addr[AW+1:2];
   assign cpu_oor    = |mem_addr[31:AW+2];
   assign conf_word  = conf_addr[AW-1:0];
   assign conf_oor   = |conf_addr[31:AW];
   assign unused_addr_bits = ^mem_addr[1:0];

   // Requests are only taken in IDLE and never while the host owns the memory
   assign cpu_acc    = (state == ST_IDLE) && (mem_wren || mem_rden) && !conf_sel;
   assign cpu_wr_acc = cpu_acc && mem_wren;     // write dominates a simultaneous read
   assign cpu_rd_acc = cpu_acc && !mem_wren;
   assign conf_we_ok = conf_wren && !conf_oor;
   assign collide    = conf_we_ok && cpu_wr_acc && (conf_word == cpu_word);
   assign cpu_lane_we = (cpu_wr_acc && !cpu_oor && !collide) ? mem_wstrb : '0;

   for (genvar i = 0; i < NL; i++) begin : g_lane
      tcm_ram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk     (clk),
         .a_we    (conf_we_ok),
         .a_addr  (conf_word),
         .a_wdata (conf_wdata[8*i +: 8]),
         .a_rdata (conf_q[i]),
         .b_we    (cpu_lane_we[i]),
         .b_addr  (cpu_word),
         .b_wdata (mem_wdata[8*i +: 8]),
         .b_rdata (cpu_q[i])
      );
   end

   // CPU handshake FSM; ready/err are registered so they line up with the RESP state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         err_q     <= 1'b0;
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_acc) begin
                  err_q <= cpu_oor;
                  if (mem_wren) begin
                     state     <= ST_RESP;
                     mem_ready <= 1'b1;
                     mem_err   <= cpu_oor;
                  end else begin
                     state <= ST_RD_WAIT;
                     cnt   <= 2'(RD_LAT - RD_LAT_MIN);
                  end
               end
            end
            ST_RD_WAIT: begin
               if (cnt == 2'd0) begin
                  state     <= ST_RESP;
                  mem_ready <= 1'b1;
                  mem_err   <= err_q;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read pipeline stages 2..RD_LAT; stage 2 zeroes anything that is not a valid in-range read
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cpu_ok_q      <= 1'b0;
         conf_ok_q     <= 1'b0;
         conf_vld_pipe <= '0;
         cpu_d_pipe    <= '0;
         conf_d_pipe   <= '0;
      end else begin
         cpu_ok_q       <= cpu_rd_acc && !cpu_oor;
         conf_ok_q      <= conf_rden && !conf_oor;
         conf_vld_pipe  <= {conf_vld_pipe[RD_LAT-1:1], conf_rden};
         cpu_d_pipe[2]  <= cpu_ok_q  ? cpu_q  : '0;
         conf_d_pipe[2] <= conf_ok_q ? conf_q : '0;
         for (int k = 3; k <= RD_LAT; k++) begin
            cpu_d_pipe[k]  <= cpu_d_pipe[k-1];
            conf_d_pipe[k] <= conf_d_pipe[k-1];
         end
      end
   end

   assign mem_rdata   = cpu_d_pipe[RD_LAT];
   assign conf_rdata  = conf_d_pipe[RD_LAT];
   assign conf_rvalid = conf_vld_pipe[RD_LAT];

endmodule
